// File: rtl/fwd_select_if.sv
// Forwarding-select bus between the ID stage and the forwarding select unit.
// master : ID-stage side, drives the instruction being decoded plus flush,
//          receives the stall request and the EX operand-mux selects.
// slave  : fwd_select_unit side.
// Signals:
//   id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
//   id_dest, id_reg_write, id_mem_read, flush  (master -> slave)
//   stall, fwd_a_sel, fwd_b_sel                (slave -> master)
interface fwd_select_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush;
  logic                  stall;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_dest, id_reg_write, id_mem_read, flush,
    input  stall, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_dest, id_reg_write, id_mem_read, flush,
    output stall, fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/fwd_select_unit.sv
// Forwarding select unit for the EX-stage operand muxes of the 5-stage CPU.
// Shadows the destination register of each in-flight instruction and, at the
// edge where an instruction enters EX, registers the 4:1 mux select for each
// ALU operand. Requests a one-cycle load-use stall toward IF/ID.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active-low
//   bus    fwd_select_if.slave (ID instruction fields, flush in;
//          stall, fwd_a_sel, fwd_b_sel out)
// Select codes: 00 register file, 01 MEM/WB result, 10 EX/MEM ALU result,
//               11 post-WB latch.
module fwd_select_unit #(
  parameter int REG_ADDR_W       = 5,
  parameter int ENABLE_WB_BYPASS = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  fwd_select_if.slave    bus
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_MEMWB = 2'b01;
  localparam logic [1:0] SEL_EXMEM = 2'b10;
  localparam logic [1:0] SEL_PWB   = 2'b11;

  // Shadow slots. Matching against the WB slot at issue time is what selects
  // the post-WB latch: by the time the consumer is in EX, that producer has
  // moved one stage further, into the latch itself.
  logic [REG_ADDR_W-1:0] ex_dest, mem_dest, wb_dest;
  logic                  ex_wr, mem_wr, wb_wr;
  logic                  ex_ld;

  logic                  load_hit;
  logic                  stall_c;
  logic                  issue;
  logic [1:0]            a_nxt, b_nxt;
  logic [1:0]            fwd_a_q, fwd_b_q;

  // Newest producer wins; register 0 never forwards.
  function automatic logic [1:0] pick_sel(
    input logic                  go,
    input logic                  used,
    input logic [REG_ADDR_W-1:0] src,
    input logic                  exw,
    input logic [REG_ADDR_W-1:0] exd,
    input logic                  memw,
    input logic [REG_ADDR_W-1:0] memd,
    input logic                  wbw,
    input logic [REG_ADDR_W-1:0] wbd
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (go && used && (src != '0)) begin
      if (exw && (exd == src))
        sel = SEL_EXMEM;
      else if (memw && (memd == src))
        sel = SEL_MEMWB;
      else if (wbw && (wbd == src) && (ENABLE_WB_BYPASS != 0))
        sel = SEL_PWB;
    end
    return sel;
  endfunction

  always_comb begin
    load_hit = ex_ld && ex_wr && (ex_dest != '0) &&
               ((bus.id_uses_rs && (bus.id_rs == ex_dest)) ||
                (bus.id_uses_rt && (bus.id_rt == ex_dest)));
    // flush wins over stall: a killed instruction cannot wait on a load.
    stall_c = bus.id_valid && !bus.flush && load_hit;
    issue   = bus.id_valid && !bus.flush && !stall_c;
    a_nxt   = pick_sel(issue, bus.id_uses_rs, bus.id_rs, ex_wr, ex_dest,
                       mem_wr, mem_dest, wb_wr, wb_dest);
    b_nxt   = pick_sel(issue, bus.id_uses_rt, bus.id_rt, ex_wr, ex_dest,
                       mem_wr, mem_dest, wb_wr, wb_dest);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_dest  <= '0;
      ex_wr    <= 1'b0;
      ex_ld    <= 1'b0;
      mem_dest <= '0;
      mem_wr   <= 1'b0;
      wb_dest  <= '0;
      wb_wr    <= 1'b0;
      fwd_a_q  <= SEL_RF;
      fwd_b_q  <= SEL_RF;
    end else begin
      // MEM -> WB
      wb_dest  <= mem_dest;
      wb_wr    <= mem_wr;
      // EX -> MEM
      mem_dest <= ex_dest;
      mem_wr   <= ex_wr;
      // ID -> EX: a bubble when nothing legal issues
      if (issue) begin
        ex_dest <= bus.id_dest;
        ex_wr   <= bus.id_reg_write;
        ex_ld   <= bus.id_mem_read;
      end else begin
        ex_dest <= '0;
        ex_wr   <= 1'b0;
        ex_ld   <= 1'b0;
      end
      fwd_a_q  <= a_nxt;
      fwd_b_q  <= b_nxt;
    end
  end

  assign bus.stall     = stall_c;
  assign bus.fwd_a_sel = fwd_a_q;
  assign bus.fwd_b_sel = fwd_b_q;

endmodule

// File: tb/tb_fwd_select_unit.sv
module tb_fwd_select_unit;

  localparam int W = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fwd_select_if #(.REG_ADDR_W(W)) bus_b ();
  fwd_select_if #(.REG_ADDR_W(W)) bus_n ();

  fwd_select_unit #(.REG_ADDR_W(W), .ENABLE_WB_BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
  );
  fwd_select_unit #(.REG_ADDR_W(W), .ENABLE_WB_BYPASS(0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .bus(bus_n.slave)
  );

  typedef struct {
    logic         rstn;
    logic         v;
    logic [W-1:0] rs, rt;
    logic         urs, urt;
    logic [W-1:0] dest;
    logic         rw, mr, fl;
    logic         cs;     // compare stall this cycle
    logic         es;     // expected stall before the edge
    logic [1:0]   ea, eb; // expected selects after the edge (bypass enabled)
  } vec_t;

  typedef struct {
    logic [W-1:0] dest;
    logic         wr, ld;
  } slot_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  function automatic vec_t mk(logic rstn, logic v, int rs, int rt, logic urs, logic urt,
                              int dest, logic rw, logic mr, logic fl,
                              logic cs, logic es, int ea, int eb);
    vec_t t;
    t.rstn = rstn; t.v = v; t.rs = W'(rs); t.rt = W'(rt);
    t.urs = urs; t.urt = urt; t.dest = W'(dest);
    t.rw = rw; t.mr = mr; t.fl = fl;
    t.cs = cs; t.es = es; t.ea = 2'(ea); t.eb = 2'(eb);
    return t;
  endfunction

  function automatic vec_t nop();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endfunction

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst_n = t.rstn;
    bus_b.id_valid = t.v;      bus_n.id_valid = t.v;
    bus_b.id_rs = t.rs;        bus_n.id_rs = t.rs;
    bus_b.id_rt = t.rt;        bus_n.id_rt = t.rt;
    bus_b.id_uses_rs = t.urs;  bus_n.id_uses_rs = t.urs;
    bus_b.id_uses_rt = t.urt;  bus_n.id_uses_rt = t.urt;
    bus_b.id_dest = t.dest;    bus_n.id_dest = t.dest;
    bus_b.id_reg_write = t.rw; bus_n.id_reg_write = t.rw;
    bus_b.id_mem_read = t.mr;  bus_n.id_mem_read = t.mr;
    bus_b.flush = t.fl;        bus_n.flush = t.fl;
  endtask

  task automatic run_cycle(input vec_t t);
    drive(t);
    @(negedge clk);
    if (t.cs) begin
      chk("stall_byp", {1'b0, bus_b.stall}, {1'b0, t.es});
      chk("stall_nobyp", {1'b0, bus_n.stall}, {1'b0, t.es});
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("fwd_a_byp", bus_b.fwd_a_sel, t.ea);
    chk("fwd_b_byp", bus_b.fwd_b_sel, t.eb);
    chk("fwd_a_nobyp", bus_n.fwd_a_sel, (t.ea == 2'b11) ? 2'b00 : t.ea);
    chk("fwd_b_nobyp", bus_n.fwd_b_sel, (t.eb == 2'b11) ? 2'b00 : t.eb);
  endtask

  // Reference model: hist[0] is the instruction issued last cycle (now in EX),
  // hist[1] two cycles ago, hist[2] three cycles ago. Age picks the source.
  slot_t hist[$];

  function automatic logic [1:0] model_sel(logic go, logic used, logic [W-1:0] src);
    if (!go || !used || src == 0) return 2'b00;
    for (int age = 0; age < 3; age++)
      if (hist[age].wr && hist[age].dest == src)
        return (age == 0) ? 2'b10 : (age == 1) ? 2'b01 : 2'b11;
    return 2'b00;
  endfunction

  vec_t tbl[$];

  initial begin
    vec_t t;
    vec_t prev;
    slot_t s;
    logic go;

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // reset: two clocks
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    // back-to-back: add $3 ; add $5,$3,$4 -> A=10
    tbl.push_back(mk(1, 1, 1, 2, 1, 1, 3, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3, 4, 1, 1, 5, 1, 0, 0, 1, 0, 2, 0));
    repeat (3) tbl.push_back(nop());
    // one bubble -> A=01
    tbl.push_back(mk(1, 1, 1, 2, 1, 1, 3, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(nop());
    tbl.push_back(mk(1, 1, 3, 4, 1, 1, 5, 1, 0, 0, 1, 0, 1, 0));
    repeat (3) tbl.push_back(nop());
    // two bubbles -> B=11 (00 without WB bypass)
    tbl.push_back(mk(1, 1, 1, 2, 1, 1, 3, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(nop());
    tbl.push_back(nop());
    tbl.push_back(mk(1, 1, 4, 3, 1, 1, 6, 1, 0, 0, 1, 0, 0, 3));
    repeat (3) tbl.push_back(nop());
    // load-use: lw $8 ; add $9,$8,$8 stalls once, then 01/01
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 8, 1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 0, 1, 1));
    repeat (3) tbl.push_back(nop());
    // $0 producer (ALU and load) never forwards or stalls
    tbl.push_back(mk(1, 1, 1, 2, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 4, 1, 0, 0, 1, 0, 0, 0));
    repeat (3) tbl.push_back(nop());
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 4, 1, 0, 0, 1, 0, 0, 0));
    repeat (3) tbl.push_back(nop());
    // load-use under flush: no stall, bubble into EX (next consumer sees MEM only)
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 8, 1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8, 8, 1, 1, 9, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8, 2, 1, 0, 9, 1, 0, 0, 1, 0, 1, 0));
    repeat (3) tbl.push_back(nop());
    // both operands from the same slot
    tbl.push_back(mk(1, 1, 1, 2, 1, 1, 7, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 7, 7, 1, 1, 9, 1, 0, 0, 1, 0, 2, 2));
    repeat (3) tbl.push_back(nop());
    // newest producer wins; unused rt ignored
    tbl.push_back(mk(1, 1, 1, 2, 1, 1, 3, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 2, 1, 1, 3, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3, 3, 1, 0, 5, 1, 0, 0, 1, 0, 2, 0));
    repeat (3) tbl.push_back(nop());
    // unused rs is not forwarded even on a match
    tbl.push_back(mk(1, 1, 1, 2, 1, 1, 6, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 6, 6, 0, 1, 9, 1, 0, 0, 1, 0, 0, 2));
    repeat (3) tbl.push_back(nop());
    // reset in the middle of a load-use stall
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 8, 1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(nop());

    @(posedge clk);
    #1;
    foreach (tbl[i]) run_cycle(tbl[i]);

    // randomized phase against the reference model
    prev = nop();
    for (int n = 0; n < 400; n++) begin
      if (n == 0) begin
        t = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end else if (prev.es) begin
        t = prev;                        // ID holds its instruction while stalled
        t.rstn = ($urandom_range(0, 99) != 0);
        t.fl = ($urandom_range(0, 7) == 0);
      end else begin
        t.rstn = ($urandom_range(0, 99) != 0);
        t.v    = ($urandom_range(0, 3) != 0);
        t.rs   = W'($urandom_range(0, 7));
        t.rt   = W'($urandom_range(0, 7));
        t.urs  = ($urandom_range(0, 3) != 0);
        t.urt  = ($urandom_range(0, 1) != 0);
        t.dest = W'($urandom_range(0, 7));
        t.rw   = ($urandom_range(0, 4) != 0);
        t.mr   = ($urandom_range(0, 3) == 0);
        t.fl   = ($urandom_range(0, 7) == 0);
      end
      t.cs = (n != 0);
      if (hist.size() == 3)
        t.es = t.v && !t.fl && hist[0].ld && hist[0].wr && hist[0].dest != 0 &&
               ((t.urs && t.rs == hist[0].dest) || (t.urt && t.rt == hist[0].dest));
      else
        t.es = 1'b0;
      go = t.v && !t.fl && !t.es;
      if (!t.rstn) begin
        t.ea = 2'b00;
        t.eb = 2'b00;
        hist.delete();
        s.dest = '0; s.wr = 1'b0; s.ld = 1'b0;
        repeat (3) hist.push_back(s);
      end else begin
        t.ea = model_sel(go, t.urs, t.rs);
        t.eb = model_sel(go, t.urt, t.rt);
        s.dest = go ? t.dest : '0;
        s.wr   = go && t.rw;
        s.ld   = go && t.mr;
        hist.push_front(s);
        void'(hist.pop_back());
      end
      run_cycle(t);
      prev = t;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
